// File: rtl/dma_copy.sv
// dma_copy: bus-master block-copy engine.
// Takes the memory bus from the CPU arbiter and copies len bytes from src to
// dst using one read cycle followed by one write cycle per byte, three clocks
// per byte with no idle bus cycles in between.
//
// Ports:
//   ph1            clock, all state changes on its rising edge
//   reset          synchronous active-low reset
//   start          one-cycle request, samples src/dst/len, ignored unless idle
//   src/dst/len    source address, destination address, byte count
//   abort          stop at the next byte boundary (sampled in REQ and WR only)
//   bus_req        request to the CPU arbiter
//   bus_gnt        grant, held by the arbiter while bus_req is high
//   bus_en         engine owns the bus; external mux selects address/rws
//   address        registered bus address
//   data           bus data, driven only while writing, otherwise Z
//   read_write_sel registered direction, 1=read 0=write
//   busy           high from the accepted start until done
//   done           one-cycle completion pulse
//   err            destination range outside RAM; held until next start
//   aborted        transfer ended by abort; held until next start
//   remaining      bytes not yet written
module dma_copy #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 13
) (
    input  logic              ph1,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              bus_en,
    output logic [ADDR_W-1:0] address,
    inout  wire  [DATA_W-1:0] data,
    output logic              read_write_sel,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              aborted,
    output logic [LEN_W-1:0]  remaining
);

    // One extra bit so the end-of-destination sum cannot wrap.
    localparam int unsigned EXT_W = ADDR_W + 1;
    localparam logic [EXT_W-1:0] RAM_TOP = EXT_W'(12'hFFF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD_A,
        S_RD_D,
        S_WR,
        S_FIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [DATA_W-1:0] hold_reg;
    logic [EXT_W-1:0]  dst_last_c;
    logic              range_bad_c;

    // Last destination byte of the requested transfer (only meaningful for len>0).
    assign dst_last_c  = {1'b0, dst} + EXT_W'(len) - EXT_W'(1);
    assign range_bad_c = (dst_last_c > RAM_TOP);

    // Drive only during WR; rws goes low on the edge entering WR, so a memory
    // read can never overlap the engine's drive.
    assign data = (bus_en && !read_write_sel) ? hold_reg : {DATA_W{1'bz}};

    // Control FSM with registered outputs.
    always_ff @(posedge ph1) begin
        if (!reset) begin
            state          <= S_IDLE;
            src_ptr        <= '0;
            dst_ptr        <= '0;
            hold_reg       <= '0;
            bus_req        <= 1'b0;
            bus_en         <= 1'b0;
            address        <= '0;
            read_write_sel <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            aborted        <= 1'b0;
            remaining      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_ptr   <= src;
                        dst_ptr   <= dst;
                        remaining <= len;
                        err       <= 1'b0;
                        aborted   <= 1'b0;
                        busy      <= 1'b1;
                        if (len == '0) begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else if (range_bad_c) begin
                            // Rejected before any bus cycle is issued.
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            bus_req <= 1'b1;
                            state   <= S_REQ;
                        end
                    end
                end

                S_REQ: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        done    <= 1'b1;
                        state   <= S_FIN;
                    end else if (bus_gnt) begin
                        bus_en         <= 1'b1;
                        address        <= src_ptr;
                        read_write_sel <= 1'b1;
                        state          <= S_RD_A;
                    end
                end

                // Memory samples the read address on the closing edge.
                S_RD_A: begin
                    state <= S_RD_D;
                end

                // Capture read data and turn the bus around for the write.
                S_RD_D: begin
                    hold_reg       <= data;
                    address        <= dst_ptr;
                    read_write_sel <= 1'b0;
                    state          <= S_WR;
                end

                // Memory writes on the closing edge; abort only takes effect here,
                // so a read is never separated from its write.
                S_WR: begin
                    src_ptr        <= src_ptr + ADDR_W'(1);
                    dst_ptr        <= dst_ptr + ADDR_W'(1);
                    remaining      <= remaining - LEN_W'(1);
                    read_write_sel <= 1'b1;
                    if ((remaining == LEN_W'(1)) || abort) begin
                        aborted <= (remaining != LEN_W'(1));
                        done    <= 1'b1;
                        state   <= S_FIN;
                    end else begin
                        address <= src_ptr + ADDR_W'(1);
                        state   <= S_RD_A;
                    end
                end

                // done is high during this cycle; the bus is released on exit.
                S_FIN: begin
                    bus_req <= 1'b0;
                    bus_en  <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy with a RAM/ROM bus model, a write monitor and an
// expected-write queue compared against the observed writes.
module tb_dma_copy;

    logic        ph1 = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] src;
    logic [15:0] dst;
    logic [12:0] len;
    logic        abort;
    logic        bus_req;
    logic        bus_gnt;
    logic        bus_en;
    logic [15:0] address;
    wire  [7:0]  data;
    logic        read_write_sel;
    logic        busy;
    logic        done;
    logic        err;
    logic        aborted;
    logic [12:0] remaining;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t exp_q[$];

    // Bus memory: RAM 0000-0FFF, ROM F000-FFFF, everything else reads 0.
    logic [7:0]  mem [0:65535];
    logic [7:0]  rd_byte;
    logic        pre_en;
    logic [15:0] pre_addr;
    logic [7:0]  pre_val;

    // Write monitor log and bus_req cycle count.
    logic [15:0] act_a [0:63];
    logic [7:0]  act_d [0:63];
    int          wr_cnt  = 0;
    int          req_cnt = 0;
    int          rd_idx  = 0;

    dma_copy dut (
        .ph1            (ph1),
        .reset          (reset),
        .start          (start),
        .src            (src),
        .dst            (dst),
        .len            (len),
        .abort          (abort),
        .bus_req        (bus_req),
        .bus_gnt        (bus_gnt),
        .bus_en         (bus_en),
        .address        (address),
        .data           (data),
        .read_write_sel (read_write_sel),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .aborted        (aborted),
        .remaining      (remaining)
    );

    always #5 ph1 = ~ph1;

    always @(posedge ph1) cyc <= cyc + 1;

    always_comb begin
        if (address <= 16'h0FFF || address >= 16'hF000) rd_byte = mem[address];
        else                                            rd_byte = 8'h00;
    end

    assign data = (bus_en && read_write_sel) ? rd_byte : 8'hzz;

    always @(posedge ph1) begin
        if (pre_en) mem[pre_addr] <= pre_val;
        else if (bus_en && !read_write_sel && address <= 16'h0FFF) mem[address] <= data;
    end

    always @(negedge ph1) begin
        if (bus_req) req_cnt <= req_cnt + 1;
        if (bus_en && !read_write_sel && wr_cnt < 64) begin
            act_a[wr_cnt] <= address;
            act_d[wr_cnt] <= data;
            wr_cnt        <= wr_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] v);
        pre_addr = a;
        pre_val  = v;
        pre_en   = 1'b1;
        @(negedge ph1);
        pre_en   = 1'b0;
    endtask

    task automatic start_copy(input logic [15:0] s, input logic [15:0] d,
                              input logic [12:0] l, output int scyc);
        src   = s;
        dst   = d;
        len   = l;
        start = 1'b1;
        scyc  = cyc;
        @(negedge ph1);
        start = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (bus_req !== 1'b1 && n < 10) begin
            @(negedge ph1);
            n++;
        end
        check({tag, "_req"}, 32'(bus_req), 32'd1);
    endtask

    task automatic wait_done(input int budget, input string tag, output int dcyc);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge ph1);
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        dcyc = cyc;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge ph1);
    endtask

    // Pop every expected write and compare with the monitor log in order.
    task automatic compare_writes(input string tag);
        wr_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_idx < wr_cnt) begin
                check({tag, "_wr_addr"}, 32'(act_a[rd_idx]), 32'(e.a));
                check({tag, "_wr_data"}, 32'(act_d[rd_idx]), 32'(e.d));
                rd_idx++;
            end else begin
                check({tag, "_wr_missing"}, 32'(wr_cnt), 32'(rd_idx + 1));
            end
        end
        check({tag, "_wr_extra"}, 32'(wr_cnt), 32'(rd_idx));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},    32'(busy),           32'd0);
        check({tag, "_bus_req"}, 32'(bus_req),        32'd0);
        check({tag, "_bus_en"},  32'(bus_en),         32'd0);
        check({tag, "_rws"},     32'(read_write_sel), 32'd1);
        check({tag, "_done"},    32'(done),           32'd0);
        check({tag, "_data_z"},  {24'h0, data},       {24'h0, 8'hzz});
    endtask

    initial begin
        int scyc;
        int gcyc;
        int dcyc;
        int req0;

        reset    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        bus_gnt  = 1'b0;
        src      = '0;
        dst      = '0;
        len      = '0;
        pre_en   = 1'b0;
        pre_addr = '0;
        pre_val  = '0;

        // Reset and idle.
        repeat (3) @(negedge ph1);
        reset = 1'b1;
        repeat (5) @(negedge ph1);
        check_idle("rst");
        check("rst_err",       32'(err),       32'd0);
        check("rst_aborted",   32'(aborted),   32'd0);
        check("rst_remaining", 32'(remaining), 32'd0);
        check("rst_address",   32'(address),   32'd0);

        // Memory image.
        preload(16'hF000, 8'hA9);
        preload(16'hF001, 8'h01);
        preload(16'hF002, 8'h8D);
        preload(16'hF003, 8'h00);
        preload(16'h0203, 8'hFF);
        preload(16'h0FFE, 8'h11);
        preload(16'h0FFF, 8'h22);
        preload(16'hFFFF, 8'h5A);
        preload(16'h0000, 8'h3C);
        for (int i = 0; i < 8; i++) preload(16'h0010 + 16'(i), 8'h80 + 8'(i));
        preload(16'h0503, 8'hEE);
        for (int i = 0; i < 4; i++) preload(16'h0020 + 16'(i), 8'h71 + 8'(i));
        preload(16'h0601, 8'hEE);
        preload(16'h0700, 8'h55);

        // ROM to RAM copy, grant two cycles after request.
        exp_q.push_back('{a: 16'h0200, d: 8'hA9});
        exp_q.push_back('{a: 16'h0201, d: 8'h01});
        exp_q.push_back('{a: 16'h0202, d: 8'h8D});
        exp_q.push_back('{a: 16'h0203, d: 8'h00});
        start_copy(16'hF000, 16'h0200, 13'd4, scyc);
        check("rom_busy", 32'(busy), 32'd1);
        wait_req("rom");
        repeat (2) @(negedge ph1);
        bus_gnt = 1'b1;
        gcyc    = cyc + 1;
        wait_done(40, "rom", dcyc);
        check("rom_latency",   32'(dcyc - gcyc), 32'd12);
        check("rom_remaining", 32'(remaining),   32'd0);
        check("rom_err",       32'(err),         32'd0);
        check("rom_aborted",   32'(aborted),     32'd0);
        @(negedge ph1);
        bus_gnt = 1'b0;
        check_idle("rom_end");
        compare_writes("rom");
        check("rom_m0", 32'(mem[16'h0200]), 32'hA9);
        check("rom_m1", 32'(mem[16'h0201]), 32'h01);
        check("rom_m2", 32'(mem[16'h0202]), 32'h8D);
        check("rom_m3", 32'(mem[16'h0203]), 32'h00);

        // Destination past the top of RAM.
        req0 = req_cnt;
        start_copy(16'h0100, 16'h0FFE, 13'd3, scyc);
        wait_done(2, "range", dcyc);
        check("range_latency",   32'(dcyc - scyc), 32'd1);
        check("range_err",       32'(err),         32'd1);
        check("range_remaining", 32'(remaining),   32'd3);
        @(negedge ph1);
        check("range_err_held", 32'(err),     32'd1);
        check("range_done_low", 32'(done),    32'd0);
        check("range_no_req",   32'(req_cnt), 32'(req0));
        check("range_m0", 32'(mem[16'h0FFE]), 32'h11);
        check("range_m1", 32'(mem[16'h0FFF]), 32'h22);
        compare_writes("range");

        // Zero length.
        req0 = req_cnt;
        start_copy(16'h0100, 16'h0400, 13'd0, scyc);
        wait_done(2, "zero", dcyc);
        check("zero_latency", 32'(dcyc - scyc), 32'd1);
        check("zero_err",     32'(err),         32'd0);
        @(negedge ph1);
        check_idle("zero_end");
        check("zero_no_req", 32'(req_cnt), 32'(req0));
        compare_writes("zero");

        // Source address wraps from FFFF to 0000.
        exp_q.push_back('{a: 16'h0300, d: 8'h5A});
        exp_q.push_back('{a: 16'h0301, d: 8'h3C});
        start_copy(16'hFFFF, 16'h0300, 13'd2, scyc);
        wait_req("wrap");
        bus_gnt = 1'b1;
        wait_done(30, "wrap", dcyc);
        check("wrap_remaining", 32'(remaining), 32'd0);
        @(negedge ph1);
        bus_gnt = 1'b0;
        check_idle("wrap_end");
        compare_writes("wrap");
        check("wrap_m0", 32'(mem[16'h0300]), 32'h5A);
        check("wrap_m1", 32'(mem[16'h0301]), 32'h3C);

        // Abort raised during the third byte's data phase.
        exp_q.push_back('{a: 16'h0500, d: 8'h80});
        exp_q.push_back('{a: 16'h0501, d: 8'h81});
        exp_q.push_back('{a: 16'h0502, d: 8'h82});
        start_copy(16'h0010, 16'h0500, 13'd8, scyc);
        wait_req("abort");
        bus_gnt = 1'b1;
        gcyc    = cyc + 1;
        wait_cyc(gcyc + 7);
        check("abort_rd_rws",  32'(read_write_sel), 32'd1);
        check("abort_rd_addr", 32'(address),        32'h0012);
        abort = 1'b1;
        @(negedge ph1);
        check("abort_wr_rws",  32'(read_write_sel), 32'd0);
        check("abort_wr_addr", 32'(address),        32'h0502);
        check("abort_wr_data", {24'h0, data},       32'h82);
        @(negedge ph1);
        abort = 1'b0;
        check("abort_done",      32'(done),      32'd1);
        check("abort_aborted",   32'(aborted),   32'd1);
        check("abort_remaining", 32'(remaining), 32'd5);
        check("abort_err",       32'(err),       32'd0);
        @(negedge ph1);
        bus_gnt = 1'b0;
        check_idle("abort_end");
        check("abort_held", 32'(aborted), 32'd1);
        compare_writes("abort");
        check("abort_m3", 32'(mem[16'h0503]), 32'hEE);

        // Second start while busy, then reset before the second byte's write.
        exp_q.push_back('{a: 16'h0600, d: 8'h71});
        start_copy(16'h0020, 16'h0600, 13'd4, scyc);
        check("rst2_aborted_clr", 32'(aborted), 32'd0);
        wait_req("rst2");
        bus_gnt = 1'b1;
        gcyc    = cyc + 1;
        wait_cyc(gcyc + 1);
        start_copy(16'h0010, 16'h0700, 13'd1, scyc);
        check("rst2_still_busy", 32'(busy), 32'd1);
        wait_cyc(gcyc + 4);
        check("rst2_rd_addr", 32'(address),        32'h0021);
        check("rst2_rd_rws",  32'(read_write_sel), 32'd1);
        reset = 1'b0;
        @(negedge ph1);
        reset   = 1'b1;
        bus_gnt = 1'b0;
        check_idle("rst2");
        check("rst2_address",   32'(address),   32'd0);
        check("rst2_remaining", 32'(remaining), 32'd0);
        repeat (3) @(negedge ph1);
        check_idle("rst2_later");
        check("rst2_m0",  32'(mem[16'h0600]), 32'h71);
        check("rst2_m1",  32'(mem[16'h0601]), 32'hEE);
        check("rst2_m70", 32'(mem[16'h0700]), 32'h55);
        compare_writes("rst2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_copy.md
Name: dma_copy

Overview:
- Bus-master block-copy engine: the initiator on the same address/data/read_write_sel memory bus the 0x0000–0x0FFF RAM / 0xF000–0xFFFF ROM memory responds on.
- Requests the bus from the CPU arbiter, then copies `len` bytes from `src` to `dst` with read-then-write bus cycles.
- Used for boot-time ROM→RAM copies and RAM block moves without CPU involvement.

Parameters:
- ADDR_W, 16, bus address width.
- DATA_W, 8, bus data width.
- LEN_W, 13, transfer length width (max 4096 bytes = full RAM).

Ports:
- ph1  input  1  clock; all state changes on posedge ph1.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request; samples src/dst/len; ignored unless idle.
- src  input  ADDR_W  source start address.
- dst  input  ADDR_W  destination start address.
- len  input  LEN_W  byte count.
- abort  input  1  stop at next byte boundary.
- bus_req  output  1  bus request to arbiter.
- bus_gnt  input  1  grant; arbiter holds it while bus_req is high.
- bus_en  output  1  engine owns bus; external mux selects engine address/rws.
- address  output  ADDR_W  bus address (registered).
- data  inout  DATA_W  bus data; driven only when bus_en=1 and read_write_sel=0, else Z.
- read_write_sel  output  1  1=read, 0=write (registered).
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle completion pulse.
- err  output  1  bad destination range; valid with done, held until next start.
- aborted  output  1  transfer ended by abort; valid with done, held until next start.
- remaining  output  LEN_W  bytes not yet written.

Behaviour:
- Reset values (reset=0 at posedge ph1): state IDLE, bus_req=0, bus_en=0, address=0, read_write_sel=1, data=Z, busy=0, done=0, err=0, aborted=0, remaining=0.
- Reset mid-transfer: IDLE on the next edge. Bytes already written stay written. No partial write is issued after reset.
- States: IDLE, REQ, RD_A, RD_D, WR, FIN.
- IDLE, start=1:
  - Latch src_ptr=src, dst_ptr=dst, remaining=len. Clear err and aborted. Set busy=1.
  - If len=0 → FIN.
  - If {1'b0,dst}+len-1 > 17'h00FFF → err=1 → FIN. No bus cycle.
  - Otherwise → REQ with bus_req=1.
- REQ: wait for bus_gnt=1 → RD_A. Set bus_en=1, address=src_ptr, read_write_sel=1. If abort=1 in REQ → aborted=1 → FIN.
- RD_A (one cycle): address and rws stable. The memory samples on the closing edge → RD_D.
- RD_D (one cycle): address and rws still held. On the closing edge, capture data into hold_reg. Load address=dst_ptr, read_write_sel=0, enable data drive with hold_reg → WR.
- WR (one cycle): data driven. The memory writes on the closing edge. On that edge:
  - src_ptr+=1 (wraps mod 2^16), dst_ptr+=1, remaining-=1, read_write_sel=1, data drive off.
  - If remaining was 1 or abort=1 → FIN, with aborted=1 if ending on abort and remaining≠1.
  - Else → RD_A with address=src_ptr+1.
- Throughput: 3 cycles per byte; no bus idle cycles between bytes.
- FIN (one cycle): done=1, bus_req=0, bus_en=0, busy=0 on the exit edge → IDLE.
- Abort is sampled only in REQ and WR; it never splits a read from its write.
- start while busy is ignored.
- Data tri-state: zero overlap with a memory read, since drive enables only on the edge entering WR.
- Source reads may target any address; unmapped reads return 0 and are copied as 0.

Test Plan:
- Reset, then idle 5 cycles → read_write_sel=1, data=Z, bus_req=0, all status 0.
- ROM preload F000:{A9,01,8D,00}; start src=F000 dst=0200 len=4; gnt 2 cycles after req → RAM[0200..0203]=A9,01,8D,00; done pulses exactly 12 cycles after grant; remaining=0; err=0.
- start src=0100 dst=0FFE len=3 → err=1, done within 2 cycles, bus_req never asserted, RAM unchanged.
- len=0 → done one cycle after start; no bus activity. Separately, src=FFFF len=2 dst=0300 → reads FFFF then 0000 (wrap).
- len=8 copy, abort=1 during the 3rd byte's RD_D → exactly 3 bytes written, aborted=1, remaining=5, bus released.
- reset=0 held one cycle during 2nd byte's WR-1 → IDLE next edge, RAM holds byte 0 only, data=Z; a second start during busy is ignored.
